// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - command sequencer driving an 8x8 register file through a small ALU
// Optional build macro: RFC_SAT_ARITH_EN (saturating ADD/SUB; carry still reports raw carry/borrow)
module regfile_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK_i,
    input  logic              RES_ni,
    input  logic              CMD_VALID_i,
    output logic              CMD_READY_o,
    input  logic [2:0]        CMD_OP_i,
    input  logic [ADDR_W-1:0] CMD_DST_i,
    input  logic [ADDR_W-1:0] CMD_SRC1_i,
    input  logic [ADDR_W-1:0] CMD_SRC2_i,
    input  logic [DATA_W-1:0] CMD_IMM_i,
    output logic              RSP_VALID_o,
    input  logic              RSP_READY_i,
    output logic [DATA_W-1:0] RSP_DATA_o,
    output logic              RSP_CARRY_o,
    output logic              WRT_EN_o,
    output logic [ADDR_W-1:0] WRT_DEST_o,
    output logic [DATA_W-1:0] WRT_DATA_o,
    output logic [ADDR_W-1:0] READ_ADDR1_o,
    output logic [ADDR_W-1:0] READ_ADDR2_o,
    input  logic [DATA_W-1:0] RD_DATA1_i,
    input  logic [DATA_W-1:0] RD_DATA2_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDI = 3'd1;
    localparam logic [2:0] OP_MOV = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_RD  = 3'd7;

    state_t            state;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] imm_q;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] result;
    logic              carry;

    // ALU: operands come straight from the register file read ports during EXEC
    always_comb begin
        sum    = {1'b0, RD_DATA1_i} + {1'b0, RD_DATA2_i};
        diff   = {1'b0, RD_DATA1_i} - {1'b0, RD_DATA2_i};
        result = '0;
        carry  = 1'b0;
        case (op_q)
            OP_LDI: result = imm_q;
            OP_MOV: result = RD_DATA1_i;
            OP_ADD: begin
                carry = sum[DATA_W];
`ifdef RFC_SAT_ARITH_EN
                result = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
                result = sum[DATA_W-1:0];
`endif
            end
            OP_SUB: begin
                // borrow shows up as the wrap into the extra top bit
                carry = diff[DATA_W];
`ifdef RFC_SAT_ARITH_EN
                result = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
                result = diff[DATA_W-1:0];
`endif
            end
            OP_AND: result = RD_DATA1_i & RD_DATA2_i;
            OP_OR:  result = RD_DATA1_i | RD_DATA2_i;
            OP_RD:  result = RD_DATA1_i;
            default: result = '0;
        endcase
    end

    // write data must be valid inside EXEC itself so the register file captures it at the end of that cycle
    assign WRT_DATA_o = (state == EXEC && WRT_EN_o) ? result : '0;

    // sequencer: IDLE accepts, EXEC reads/writes for one cycle, RESP holds the response until taken
    always_ff @(posedge CLK_i) begin
        if (!RES_ni) begin
            state        <= IDLE;
            op_q         <= OP_NOP;
            imm_q        <= '0;
            CMD_READY_o  <= 1'b0;
            RSP_VALID_o  <= 1'b0;
            RSP_DATA_o   <= '0;
            RSP_CARRY_o  <= 1'b0;
            WRT_EN_o     <= 1'b0;
            WRT_DEST_o   <= '0;
            READ_ADDR1_o <= '0;
            READ_ADDR2_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    CMD_READY_o <= 1'b1;
                    // NOP is consumed in place; outputs are left untouched
                    if (CMD_VALID_i && CMD_READY_o && CMD_OP_i != OP_NOP) begin
                        op_q         <= CMD_OP_i;
                        imm_q        <= CMD_IMM_i;
                        READ_ADDR1_o <= CMD_SRC1_i;
                        READ_ADDR2_o <= CMD_SRC2_i;
                        WRT_DEST_o   <= CMD_DST_i;
                        WRT_EN_o     <= (CMD_OP_i != OP_RD);
                        CMD_READY_o  <= 1'b0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    WRT_EN_o    <= 1'b0;
                    RSP_DATA_o  <= result;
                    RSP_CARRY_o <= carry;
                    RSP_VALID_o <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (RSP_READY_i) begin
                        RSP_VALID_o <= 1'b0;
                        CMD_READY_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - self-checking bench for regfile_ctrl with a behavioural register file model
module tb_regfile_ctrl;

`ifdef RFC_SAT_ARITH_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       resn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_dst;
    logic [2:0] cmd_src1;
    logic [2:0] cmd_src2;
    logic [7:0] cmd_imm;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       wrt_en;
    logic [2:0] wrt_dest;
    logic [7:0] wrt_data;
    logic [2:0] read_addr1;
    logic [2:0] read_addr2;
    logic [7:0] rd_data1;
    logic [7:0] rd_data2;

    logic [7:0] rf [8];
    int         model_rf [8];
    int         total;
    int         bad;

    regfile_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .CLK_i        (clk),
        .RES_ni       (resn),
        .CMD_VALID_i  (cmd_valid),
        .CMD_READY_o  (cmd_ready),
        .CMD_OP_i     (cmd_op),
        .CMD_DST_i    (cmd_dst),
        .CMD_SRC1_i   (cmd_src1),
        .CMD_SRC2_i   (cmd_src2),
        .CMD_IMM_i    (cmd_imm),
        .RSP_VALID_o  (rsp_valid),
        .RSP_READY_i  (rsp_ready),
        .RSP_DATA_o   (rsp_data),
        .RSP_CARRY_o  (rsp_carry),
        .WRT_EN_o     (wrt_en),
        .WRT_DEST_o   (wrt_dest),
        .WRT_DATA_o   (wrt_data),
        .READ_ADDR1_o (read_addr1),
        .READ_ADDR2_o (read_addr2),
        .RD_DATA1_i   (rd_data1),
        .RD_DATA2_i   (rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file: combinational read, write at the clock edge
    assign rd_data1 = rf[read_addr1];
    assign rd_data2 = rf[read_addr2];
    always @(posedge clk) if (wrt_en) rf[wrt_dest] <= wrt_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference semantics written from the opcode table
    task automatic ref_op(input int op, input int a, input int b, input int imm,
                          output int res, output int cy, output bit wr);
        res = 0; cy = 0; wr = 1'b1;
        case (op)
            0: wr = 1'b0;
            1: res = imm;
            2: res = a;
            3: begin
                res = a + b;
                cy  = (res > 255) ? 1 : 0;
                if (cy == 1) res = SAT ? 255 : res - 256;
            end
            4: begin
                cy  = (a < b) ? 1 : 0;
                res = a - b;
                if (res < 0) res = SAT ? 0 : res + 256;
            end
            5: res = a & b;
            6: res = a | b;
            default: begin res = a; wr = 1'b0; end
        endcase
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, cmd_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_carry"}, rsp_carry, 0);
        chk({tag, "_wr_en"}, wrt_en, 0);
        chk({tag, "_wr_dest"}, wrt_dest, 0);
        chk({tag, "_wr_data"}, wrt_data, 0);
        chk({tag, "_raddr1"}, read_addr1, 0);
        chk({tag, "_raddr2"}, read_addr2, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", cmd_ready, 1);
    endtask

    // one full command: accept, EXEC, RESP with stall, handshake
    task automatic issue(input int op, input int dst, input int s1, input int s2,
                         input int imm, input int stall);
        int res, cy;
        bit wr;
        wait_ready();
        ref_op(op, model_rf[s1], model_rf[s2], imm, res, cy, wr);
        cmd_valid = 1'b1;
        cmd_op = op[2:0]; cmd_dst = dst[2:0]; cmd_src1 = s1[2:0]; cmd_src2 = s2[2:0];
        cmd_imm = imm[7:0];
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = $urandom; cmd_dst = $urandom; cmd_src1 = $urandom; cmd_src2 = $urandom;
        cmd_imm = $urandom;
        if (op == 0) begin
            chk("nop_wr_en", wrt_en, 0);
            chk("nop_rsp_valid", rsp_valid, 0);
            chk("nop_ready", cmd_ready, 1);
            return;
        end
        chk("exec_ready", cmd_ready, 0);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_wr_en", wrt_en, {31'd0, wr});
        if (wr) begin
            chk("exec_wr_dest", wrt_dest, dst);
            chk("exec_wr_data", wrt_data, res);
        end
        @(posedge clk); #1;
        if (wr) model_rf[dst] = res;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, res);
        chk("rsp_carry", rsp_carry, cy);
        chk("rsp_wr_en", wrt_en, 0);
        chk("rsp_ready", cmd_ready, 0);
        for (int i = 0; i < stall; i++) begin
            cmd_valid = $urandom_range(0, 1);
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, res);
            chk("hold_wr_en", wrt_en, 0);
            chk("hold_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("done_valid", rsp_valid, 0);
        chk("done_ready", cmd_ready, 1);
        if (wr) chk("rf_content", rf[dst], model_rf[dst]);
    endtask

    initial begin
        total = 0; bad = 0;
        for (int i = 0; i < 8; i++) model_rf[i] = 0;
        resn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 3'd0; cmd_dst = 3'd0; cmd_src1 = 3'd0; cmd_src2 = 3'd0; cmd_imm = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        resn = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", cmd_ready, 1);

        // give every register a known value
        for (int i = 0; i < 8; i++) issue(1, i, 0, 0, $urandom_range(0, 255), 0);

        // directed cases
        issue(1, 3, 0, 0, 8'h5A, 0);
        issue(1, 1, 0, 0, 8'hF0, 0);
        issue(1, 2, 0, 0, 8'h20, 0);
        issue(3, 4, 1, 2, 0, 0);
        chk("add_r4", rf[4], SAT ? 8'hFF : 8'h10);
        issue(1, 1, 0, 0, 8'h05, 0);
        issue(1, 2, 0, 0, 8'h07, 0);
        issue(4, 1, 1, 2, 0, 1);
        chk("sub_r1", rf[1], SAT ? 8'h00 : 8'hFE);
        issue(7, 0, 3, 0, 0, 5);

        // NOPs back to back with valid held, then MOV in the same stream
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_dst = 3'd6;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("nop_stream_ready", cmd_ready, 1);
            chk("nop_stream_wr_en", wrt_en, 0);
            chk("nop_stream_rsp", rsp_valid, 0);
        end
        issue(2, 6, 3, 0, 0, 0);
        chk("mov_r6", rf[6], 8'h5A);

        // reset during EXEC: LDI rewrites r5 with its own value so the write edge is harmless
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_dst = 3'd5; cmd_imm = model_rf[5][7:0];
        @(posedge clk); #1;
        cmd_valid = 1'b0; resn = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("rst_exec");
        resn = 1'b1;
        @(posedge clk); #1;
        chk("rst_exec_ready", cmd_ready, 1);
        chk("rst_exec_rsp", rsp_valid, 0);

        // reset during RESP: response is dropped without a handshake
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_dst = 3'd6; cmd_src1 = 3'd3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        model_rf[6] = model_rf[3];
        chk("rst_resp_pre_valid", rsp_valid, 1);
        resn = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("rst_resp");
        resn = 1'b1;
        @(posedge clk); #1;
        chk("rst_resp_ready", cmd_ready, 1);
        chk("rst_resp_rsp", rsp_valid, 0);

        // randomized commands
        for (int n = 0; n < 60; n++)
            issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 2));

        for (int i = 0; i < 8; i++) chk("final_rf", rf[i], model_rf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
